phase_sequencer: RTL and testbench

Parametrised instruction-cycle phase generator for the CPU control path. It drives a one-hot phase vector (fetch/decode/execute/writeback generalised to PHASES phases). It adds stall, early end-of-instruction, halt/resume, an instruction-done strobe and a retired-instruction counter. Sits between the clock/reset root and the control unit; every datapath enable is qualified by one bit of phase_onehot.

---
 rtl/phase_sequencer_if.sv | 42 ++++
 rtl/phase_sequencer.sv | 87 ++++++++
 tb/tb_phase_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Control bundle between the phase sequencer and the control unit.
// The master drives the control requests; the slave reports the phase.
interface phase_sequencer_if #(
  parameter int PHASES      = 4,
  parameter int COUNT_WIDTH = 16
);
  localparam int IDX_WIDTH = $clog2(PHASES);

  logic                   stall;
  logic                   end_early;
  logic                   halt;
  logic                   resume;
  logic [PHASES-1:0]      phase_onehot;
  logic [IDX_WIDTH-1:0]   phase_index;
  logic                   instr_done;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output stall,
    output end_early,
    output halt,
    output resume,
    input  phase_onehot,
    input  phase_index,
    input  instr_done,
    input  halted,
    input  instr_count
  );

  modport slave (
    input  stall,
    input  end_early,
    input  halt,
    input  resume,
    output phase_onehot,
    output phase_index,
    output instr_done,
    output halted,
    output instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot instruction-cycle phase generator with stall, early end,
// halt/resume at instruction boundaries and a retired-instruction count.
module phase_sequencer #(
  parameter int PHASES      = 4,
  parameter int COUNT_WIDTH = 16,
  localparam int IDX_WIDTH  = $clog2(PHASES)
) (
  input logic         clock,
  input logic         reset,
  phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(PHASES - 1);

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wrap;
  logic                   done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BLANK;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Wrap on the last legal phase, not on the index width's maximum.
  assign wrap = (idx_q == LAST) || bus.end_early;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    done    = 1'b0;
    unique case (state_q)
      BLANK: begin
        state_d = RUN;
        idx_d   = '0;
      end
      RUN: begin
        if (!bus.stall) begin
          if (wrap) begin
            done    = 1'b1;
            count_d = count_q + COUNT_WIDTH'(1);
            idx_d   = '0;
            if (bus.halt) begin
              state_d = HALTED;
            end
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      HALTED: begin
        if (bus.resume) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = BLANK;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.phase_onehot = (state_q == RUN)
                          ? (PHASES'(1) << idx_q)
                          : '0;
  assign bus.phase_index  = (state_q == RUN) ? idx_q : '0;
  assign bus.instr_done   = done;
  assign bus.halted       = (state_q == HALTED);
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed literal checks plus random
// stimulus compared every cycle against a behavioural model.
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset     = 1'b1;
  logic stall     = 1'b0;
  logic end_early = 1'b0;
  logic halt      = 1'b0;
  logic resume    = 1'b0;

  phase_sequencer_if #(.PHASES(4), .COUNT_WIDTH(4))  bus4 ();
  phase_sequencer_if #(.PHASES(5), .COUNT_WIDTH(16)) bus5 ();

  assign bus4.stall     = stall;
  assign bus4.end_early = end_early;
  assign bus4.halt      = halt;
  assign bus4.resume    = resume;
  assign bus5.stall     = stall;
  assign bus5.end_early = end_early;
  assign bus5.halt      = halt;
  assign bus5.resume    = resume;

  phase_sequencer #(.PHASES(4), .COUNT_WIDTH(4)) u4 (
    .clock (clk),
    .reset (reset),
    .bus   (bus4)
  );

  phase_sequencer #(.PHASES(5), .COUNT_WIDTH(16)) u5 (
    .clock (clk),
    .reset (reset),
    .bus   (bus5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: running/halted flags, position in instruction,
  // retired count modulo the counter size.
  int  ph [2]  = '{4, 5};
  int  mod [2] = '{16, 65536};
  bit  run [2];
  bit  hlt [2];
  int  pos [2];
  int  cnt [2];
  bit  valid = 1'b0;

  function automatic bit ends_now(int p);
    return run[p] && !stall &&
           ((pos[p] == ph[p] - 1) || end_early);
  endfunction

  task automatic model_step();
    bit done [2];
    for (int p = 0; p < 2; p++) done[p] = ends_now(p);
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        run[p] = 0; hlt[p] = 0; pos[p] = 0; cnt[p] = 0;
      end else if (valid) begin
        if (hlt[p]) begin
          if (resume) begin hlt[p] = 0; run[p] = 1; pos[p] = 0; end
        end else if (!run[p]) begin
          run[p] = 1; pos[p] = 0;
        end else if (done[p]) begin
          cnt[p] = (cnt[p] + 1) % mod[p];
          pos[p] = 0;
          if (halt) begin run[p] = 0; hlt[p] = 1; end
        end else if (!stall) begin
          pos[p] = pos[p] + 1;
        end
      end
    end
    if (reset) valid = 1'b1;
  endtask

  task automatic compare();
    for (int p = 0; p < 2; p++) begin
      logic [31:0] oh, ix, dn, hl, ct;
      int          e_oh;
      if (p == 0) begin
        oh = 32'(bus4.phase_onehot); ix = 32'(bus4.phase_index);
        dn = 32'(bus4.instr_done);   hl = 32'(bus4.halted);
        ct = 32'(bus4.instr_count);
      end else begin
        oh = 32'(bus5.phase_onehot); ix = 32'(bus5.phase_index);
        dn = 32'(bus5.instr_done);   hl = 32'(bus5.halted);
        ct = 32'(bus5.instr_count);
      end
      e_oh = run[p] ? (1 << pos[p]) : 0;
      chk($sformatf("onehot[%0d]", p), oh, e_oh);
      chk($sformatf("index[%0d]", p), ix, run[p] ? pos[p] : 0);
      chk($sformatf("done[%0d]", p), dn, 32'(ends_now(p)));
      chk($sformatf("halted[%0d]", p), hl, 32'(hlt[p]));
      chk($sformatf("count[%0d]", p), ct, cnt[p]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (valid) compare();
    end
  end

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    nx();
    chk("blank_oh", 32'(bus4.phase_onehot), 0);
    chk("blank_idx5", 32'(bus5.phase_index), 0);
    for (int i = 0; i < 6; i++) begin
      nx();
      chk("seq_oh4", 32'(bus4.phase_onehot), 1 << (i % 4));
      chk("seq_done4", 32'(bus4.instr_done), (i % 4) == 3);
      chk("seq_cnt4", 32'(bus4.instr_count), i >= 4);
      chk("seq_idx5", 32'(bus5.phase_index), i % 5);
      chk("seq_done5", 32'(bus5.instr_done), i == 4);
    end
    // u4 now in phase 1 with count 1; walk to count 15 in phase 3.
    repeat (58) nx();
    chk("wrap_pre_cnt", 32'(bus4.instr_count), 15);
    chk("wrap_pre_done", 32'(bus4.instr_done), 1);
    nx();
    chk("wrap_cnt", 32'(bus4.instr_count), 0);
    chk("wrap_oh", 32'(bus4.phase_onehot), 1);
    repeat (2) nx();
    chk("rst_ph2", 32'(bus4.phase_onehot), 4);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    nx();
    chk("rst_oh", 32'(bus4.phase_onehot), 0);
    chk("rst_cnt", 32'(bus4.instr_count), 0);
    nx();
    chk("rst_ph0", 32'(bus4.phase_onehot), 1);
    repeat (2) nx();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nx();
      chk("stall_oh", 32'(bus4.phase_onehot), 4);
    end
    stall = 1'b0;
    nx();
    chk("stall_next", 32'(bus4.phase_onehot), 8);
    stall = 1'b1; end_early = 1'b1; halt = 1'b1;
    #1 chk("stall_done", 32'(bus4.instr_done), 0);
    nx();
    chk("stall_hold", 32'(bus4.phase_onehot), 8);
    chk("stall_nohalt", 32'(bus4.halted), 0);
    stall = 1'b0; end_early = 1'b0; halt = 1'b0;
    nx();
    chk("stall_wrap", 32'(bus4.phase_onehot), 1);
    nx();
    halt = 1'b1;
    nx();
    chk("halt_ph2", 32'(bus4.phase_onehot), 4);
    nx();
    chk("halt_ph3", 32'(bus4.phase_onehot), 8);
    nx();
    chk("halt_on", 32'(bus4.halted), 1);
    chk("halt_oh", 32'(bus4.phase_onehot), 0);
    repeat (5) nx();
    chk("halt_hold", 32'(bus4.halted), 1);
    halt = 1'b0; resume = 1'b1;
    nx();
    resume = 1'b0;
    chk("resume_oh", 32'(bus4.phase_onehot), 1);
    chk("resume_hl", 32'(bus4.halted), 0);
    nx();
    end_early = 1'b1;
    #1 chk("ee_done", 32'(bus4.instr_done), 1);
    nx();
    chk("ee_oh", 32'(bus4.phase_onehot), 1);
    chk("ee_done0", 32'(bus4.instr_done), 1);
    nx();
    chk("ee_oh0", 32'(bus4.phase_onehot), 1);
    end_early = 1'b0;
    repeat (3000) begin
      @(posedge clk);
      #2;
      stall     = $urandom_range(0, 99) < 25;
      end_early = $urandom_range(0, 99) < 15;
      halt      = $urandom_range(0, 99) < 30;
      resume    = $urandom_range(0, 99) < 20;
      reset     = $urandom_range(0, 199) == 0;
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
